// File: rtl/operator_pulse_gen.sv
// Keypad operator front end: synchronises and debounces four operator keys, then
// drives one clean capture pulse per accepted press on operatorPulse.
module operator_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opKeys,
    output logic [4:0] operatorPulse,
    output logic       busy
);

    // state    | meaning
    // IDLE     | no key activity, waiting for a nonzero sample
    // DEBOUNCE | single key seen, counting identical samples
    // SETUP    | code loaded, enable still low for one cycle
    // PULSE    | capture enable high
    // HOLD     | enable low again, code held for one cycle
    // RELEASE  | waiting for a debounced all-keys-up
    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SETUP,
        PULSE,
        HOLD,
        RELEASE
    } state_t;

    localparam logic [7:0] DEB_TC = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] PUL_TC = 8'(PULSE_CYCLES);

    state_t     state, state_nxt;
    logic [3:0] sync_meta, sync_keys;
    logic [7:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0] cand, cand_nxt;
    logic [3:0] code, code_nxt;
    logic       en, en_nxt;
    logic       keys_zero, keys_single;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= '0;
            sync_keys <= '0;
        end else begin
            sync_meta <= opKeys;
            sync_keys <= sync_meta;
        end
    end

    assign cnt_inc     = cnt + 8'd1;
    assign keys_zero   = (sync_keys == 4'd0);
    assign keys_single = !keys_zero && ((sync_keys & (sync_keys - 4'd1)) == 4'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cand_nxt  = cand;
        code_nxt  = code;
        en_nxt    = en;
        case (state)
            IDLE: begin
                if (keys_single) begin
                    cand_nxt  = sync_keys;
                    cnt_nxt   = 8'd1;
                    state_nxt = DEBOUNCE;
                end else if (!keys_zero) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = RELEASE;
                end
            end
            DEBOUNCE: begin
                if (sync_keys == cand) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEB_TC) begin
                        code_nxt  = cand;
                        state_nxt = SETUP;
                    end
                end else if (keys_zero) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt   = 8'd0;
                    state_nxt = RELEASE;
                end
            end
            SETUP: begin
                en_nxt    = 1'b1;
                cnt_nxt   = 8'd1;
                state_nxt = PULSE;
            end
            PULSE: begin
                // keys are deliberately ignored while the enable is high
                if (cnt == PUL_TC) begin
                    en_nxt    = 1'b0;
                    state_nxt = HOLD;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            HOLD: begin
                cnt_nxt   = 8'd0;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                if (keys_zero) begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DEB_TC) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= '0;
            code  <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            cand  <= cand_nxt;
            code  <= code_nxt;
            en    <= en_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    assign operatorPulse = {en, code};

endmodule

// File: tb/tb_operator_pulse_gen.sv
// Bench for operator_pulse_gen: two parameterisations share one key stream and are
// compared each cycle against a run-length timeline model of accepted presses.
module tb_operator_pulse_gen;

    localparam int MAXN = 4096;

    logic       clk;
    logic       rst_n;
    logic [3:0] op_keys;
    logic [4:0] pulse_a, pulse_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] stim[$];
    logic       m_busy[MAXN];
    logic       m_en[MAXN];
    logic       m_acc[MAXN];
    logic [3:0] m_acc_code[MAXN];
    logic [5:0] m_exp[MAXN];
    logic [5:0] exp_a[MAXN];
    logic [5:0] exp_b[MAXN];

    operator_pulse_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .opKeys(op_keys), .operatorPulse(pulse_a), .busy(busy_a)
    );

    operator_pulse_gen #(.DEBOUNCE_CYCLES(2), .PULSE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .opKeys(op_keys), .operatorPulse(pulse_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Key value the FSM acts on at edge e (two-flop delay, cleared by reset).
    function automatic logic [3:0] samp(input int e);
        if (e < 2) return 4'd0;
        return stim[e-2];
    endfunction

    function automatic bit is_single(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    task automatic set_busy(input int lo, input int hi, input int n);
        for (int i = lo; i <= hi && i < n; i++) m_busy[i] = 1'b1;
    endtask

    // Timeline model: a press is a run of D equal one-hot samples starting while idle;
    // the pulse then follows at fixed offsets and a run of D zeros ends the busy period.
    task automatic build_model(input int d, input int p, input int n);
        int e, r, a, b, f, z, st;
        logic [3:0] sv, code;
        for (int i = 0; i < n; i++) begin
            m_busy[i] = 1'b0; m_en[i] = 1'b0; m_acc[i] = 1'b0; m_acc_code[i] = 4'd0;
        end
        e = 0;
        while (e < n) begin
            sv = samp(e);
            st = -1;
            if (sv == 4'd0) begin
                e++;
            end else if (is_single(sv)) begin
                r = 0;
                while (r < d && e + r < n && samp(e + r) == sv) r++;
                if (r == d) begin
                    a = e + d - 1;
                    set_busy(e, a + p + 2, n);
                    m_acc[a] = 1'b1;
                    m_acc_code[a] = sv;
                    for (int i = a + 1; i <= a + p && i < n; i++) m_en[i] = 1'b1;
                    st = a + p + 3;
                end else if (e + r >= n) begin
                    set_busy(e, n - 1, n);
                    e = n;
                end else begin
                    b = e + r;
                    if (samp(b) == 4'd0) begin
                        set_busy(e, b - 1, n);
                        e = b + 1;
                    end else begin
                        set_busy(e, b, n);
                        st = b + 1;
                    end
                end
            end else begin
                set_busy(e, e, n);
                st = e + 1;
            end
            if (st >= 0) begin
                z = 0;
                for (f = st; f < n; f++) begin
                    z = (samp(f) == 4'd0) ? z + 1 : 0;
                    if (z == d) break;
                    m_busy[f] = 1'b1;
                end
                e = f + 1;
            end
        end
        code = 4'd0;
        for (int i = 0; i < n; i++) begin
            if (m_acc[i]) code = m_acc_code[i];
            m_exp[i] = {m_busy[i], m_en[i], code};
        end
    endtask

    task automatic push(input logic [3:0] v, input int len);
        for (int i = 0; i < len; i++) stim.push_back(v);
    endtask

    task automatic do_run(input string name);
        int n, rise_a, rise_b, want_rise_a, want_rise_b;
        logic [5:0] prev_a, prev_b;
        n = stim.size();
        build_model(4, 2, n);
        for (int i = 0; i < n; i++) exp_a[i] = m_exp[i];
        build_model(2, 1, n);
        for (int i = 0; i < n; i++) exp_b[i] = m_exp[i];
        want_rise_a = 0;
        want_rise_b = 0;
        for (int i = 0; i < n; i++) begin
            if (exp_a[i][4] && (i == 0 || !exp_a[i-1][4])) want_rise_a++;
            if (exp_b[i][4] && (i == 0 || !exp_b[i-1][4])) want_rise_b++;
        end

        rst_n   = 1'b0;
        op_keys = 4'd0;
        #3;
        chk_eq($sformatf("%s reset_a", name), {26'd0, busy_a, pulse_a}, 32'd0);
        chk_eq($sformatf("%s reset_b", name), {26'd0, busy_b, pulse_b}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        op_keys = stim[0];
        prev_a  = 6'd0;
        prev_b  = 6'd0;
        rise_a  = 0;
        rise_b  = 0;
        for (int e = 0; e < n; e++) begin
            @(posedge clk);
            #1;
            chk_eq($sformatf("%s a edge%0d", name, e), {26'd0, busy_a, pulse_a}, {26'd0, exp_a[e]});
            chk_eq($sformatf("%s b edge%0d", name, e), {26'd0, busy_b, pulse_b}, {26'd0, exp_b[e]});
            if (pulse_a[3:0] != prev_a[3:0])
                chk_eq($sformatf("%s a code_moved_en edge%0d", name, e), {30'd0, prev_a[4], pulse_a[4]}, 32'd0);
            if (pulse_b[3:0] != prev_b[3:0])
                chk_eq($sformatf("%s b code_moved_en edge%0d", name, e), {30'd0, prev_b[4], pulse_b[4]}, 32'd0);
            if (pulse_a[4] && !prev_a[4]) rise_a++;
            if (pulse_b[4] && !prev_b[4]) rise_b++;
            prev_a = {busy_a, pulse_a};
            prev_b = {busy_b, pulse_b};
            if (e + 1 < n) begin
                @(negedge clk);
                op_keys = stim[e+1];
            end
        end
        chk_eq($sformatf("%s rises_a", name), rise_a, want_rise_a);
        chk_eq($sformatf("%s rises_b", name), rise_b, want_rise_b);
    endtask

    initial begin
        logic [3:0] oh;
        rst_n   = 1'b0;
        op_keys = 4'd0;

        // directed: clean press, bounce, multi-key, long hold, second press
        stim.delete();
        push(4'b0100, 30); push(4'b0000, 20);
        for (int i = 0; i < 3; i++) begin push(4'b0001, 2); push(4'b0000, 2); end
        push(4'b0001, 20); push(4'b0000, 20);
        push(4'b0011, 20); push(4'b0000, 20);
        push(4'b1000, 100); push(4'b0000, 20);
        push(4'b0010, 20); push(4'b0000, 20);
        do_run("directed");

        // randomised segments
        stim.delete();
        for (int s = 0; s < 30; s++) begin
            oh = 4'b0001 << $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: push(4'b0000, $urandom_range(1, 15));
                1: push(oh, $urandom_range(1, 30));
                2: begin
                    for (int t = 0; t < int'($urandom_range(1, 4)); t++) begin
                        push(oh, $urandom_range(1, 3));
                        push(4'b0000, $urandom_range(1, 3));
                    end
                    push(oh, $urandom_range(1, 12));
                end
                default: push(4'($urandom_range(0, 15)), $urandom_range(1, 10));
            endcase
            if ($urandom_range(0, 1) == 1) push(4'b0000, $urandom_range(1, 10));
        end
        do_run("random");

        // stop with the D=4,P=2 enable high, then reset asynchronously mid-pulse
        stim.delete();
        push(4'b0100, 7);
        do_run("midpulse");
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("async_reset_a", {26'd0, busy_a, pulse_a}, 32'd0);
        chk_eq("async_reset_b", {26'd0, busy_b, pulse_b}, 32'd0);

        // quiet after reset, then a single press for the short parameter set
        stim.delete();
        push(4'b0000, 12);
        push(4'b0010, 15);
        push(4'b0000, 15);
        do_run("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
